serial2parallel: RTL
====================

SERIAL2PARALLEL -- requirements
Module: serial2parallel

Interface
REQ-001 Parameter: DATA_WIDTH, default 4, deserialized word width in bits; legal range is DATA_WIDTH >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 serin  input  1  serial data bit, sampled every clk edge, MSB first.
REQ-005 start  input  1  high in the same cycle as the first (MSB) bit of a word.
REQ-006 parout  output  DATA_WIDTH  assembled word; stable while parout_valid=1.
REQ-007 parout_valid  output  1  parout holds an unconsumed word.
REQ-008 parout_ready  input  1  consumer accepts parout when parout_valid & parout_ready at a clk edge.
REQ-009 busy  output  1  FSM is in SHIFT, i.e. a word is partially received.
REQ-010 overrun  output  1  one-cycle pulse: a completed word was dropped because the output register was full.
REQ-011 frame_error  output  1  one-cycle pulse: a partial word was aborted by a new start.

Function
REQ-012 FSM states: IDLE and SHIFT; a bit counter counts 0..DATA_WIDTH-1 and a shift register holds DATA_WIDTH bits.
REQ-013 IDLE, start=1: shift register LSB <= serin, counter <= 1, go to SHIFT.
REQ-014 IDLE, start=0: serin is ignored and the state is held.
REQ-015 SHIFT, start=0, counter < DATA_WIDTH-1: shift register left-shifts with serin as the new LSB, and counter increments.
REQ-016 SHIFT, start=0, counter = DATA_WIDTH-1: the final bit shifts in; the word {shift[DATA_WIDTH-2:0], serin} is complete, and the FSM returns to IDLE with counter <= 0.
REQ-017 SHIFT, start=1 (at any counter value, including the final-bit cycle): the partial word is discarded, frame_error pulses for 1 cycle, and the behaviour is identical to REQ-013 (start has priority over completion).
REQ-018 Completion latency: parout_valid rises at the same clk edge that samples the final bit, so it is visible in the following cycle.
REQ-019 On completion, parout loads the word when parout_valid=0, or when parout_valid=1 and parout_ready=1 in that cycle (simultaneous consume and refill); in the refill case parout_valid stays 1.
REQ-020 On completion with parout_valid=1 and parout_ready=0: the new word is dropped, parout is unchanged, and overrun pulses for 1 cycle.
REQ-021 parout_valid=1 and parout_ready=1 with no completion: parout_valid <= 0 at that edge; parout keeps its last value.
REQ-022 parout_ready is ignored while parout_valid=0.
REQ-023 busy = 1 exactly while the state is SHIFT.
REQ-024 Back-to-back words are supported: start may be asserted in the cycle immediately after a final bit, with no gap required.
REQ-025 overrun and frame_error are each high for exactly one cycle per event and are never asserted by reset.

Reset
REQ-026 While reset=1, the block asynchronously forces: state=IDLE, counter=0, shift register=0, parout=0, parout_valid=0, busy=0, overrun=0, frame_error=0.
REQ-027 Reset asserted mid-word discards the partial word and any held parout without an overrun or frame_error pulse.
REQ-028 After reset deasserts, the first start accepted is the one sampled at the first rising edge with reset=0.

Verification (DATA_WIDTH=4)
REQ-029 Basic: start=1 with serin=1, then serin 0,1,1 (parout_ready=1) -> after the 4th edge, parout=4'hB and parout_valid=1 for 1 cycle; busy is high for 3 cycles.
REQ-030 Backpressure: parout_ready=0; send 4'hB, then 4'h5 back-to-back -> parout stays 4'hB and overrun pulses once on the 8th edge; raising ready then clears valid.
REQ-031 Simultaneous: 4'hB held; the final bit of 4'h6 arrives in the same cycle as parout_ready=1 -> parout=4'h6, valid stays 1, no overrun.
REQ-032 Abort: start, 2 bits, then start with a new word 4'h9 -> frame_error pulses once, parout=4'h9 after 4 more bits.
REQ-033 Reset mid-word: assert reset asynchronously after 2 bits -> all outputs 0 immediately; the next full word 4'hC is received correctly.
REQ-034 Upstream chain: connect to the parallel-to-serial stage with start aligned to its first data bit -> 8 random words are recovered in order with no overrun while parout_ready=1.

Source files
------------

// File: rtl/serial2parallel_if.sv
// Handshake bundle between a serial bit source, the deserializer and the word consumer.
interface serial2parallel_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  serin;
  logic                  start;
  logic [DATA_WIDTH-1:0] parout;
  logic                  parout_valid;
  logic                  parout_ready;
  logic                  busy;
  logic                  overrun;
  logic                  frame_error;

  modport master (
    output serin, start, parout_ready,
    input  parout, parout_valid, busy, overrun, frame_error
  );

  modport slave (
    input  serin, start, parout_ready,
    output parout, parout_valid, busy, overrun, frame_error
  );
endinterface

// File: rtl/serial2parallel.sv
// MSB-first serial-to-parallel deserializer with a one-word output register,
// valid/ready handoff, and overrun / frame-error event pulses.
module serial2parallel #(
  parameter int DATA_WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  serial2parallel_if.slave   bus
);
  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  // Only the bits ahead of the final one are stored; the final bit goes straight into the word.
  logic [DATA_WIDTH-2:0] shift_reg;
  logic [DATA_WIDTH-1:0] word;

  assign word = {shift_reg, bus.serin};

  // NOTE: every register here is updated with <= so all branches see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      shift_reg        <= '0;
      bus.parout       <= '0;
      bus.parout_valid <= 1'b0;
      bus.busy         <= 1'b0;
      bus.overrun      <= 1'b0;
      bus.frame_error  <= 1'b0;
    end else begin
      bus.overrun     <= 1'b0;
      bus.frame_error <= 1'b0;

      if (bus.parout_valid && bus.parout_ready) begin
        bus.parout_valid <= 1'b0;
      end

      // A new start wins over completing the current word.
      if (bus.start) begin
        bus.frame_error <= (state == SHIFT);
        shift_reg       <= (DATA_WIDTH-1)'(bus.serin);
        bit_cnt         <= CNT_W'(1);
        state           <= SHIFT;
        bus.busy        <= 1'b1;
      end else if (state == SHIFT) begin
        shift_reg <= word[DATA_WIDTH-2:0];
        if (bit_cnt == LAST_BIT) begin
          state    <= IDLE;
          bit_cnt  <= '0;
          bus.busy <= 1'b0;
          if (!bus.parout_valid || bus.parout_ready) begin
            bus.parout       <= word;
            bus.parout_valid <= 1'b1;
          end else begin
            bus.overrun <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule
